conv2d_seq: RTL
===============

Name: conv2d_seq

Overview:
- Sequential, multi-filter 3x3 2-D convolution engine in signed Qm.Q fixed point.
- It is the successor to the combinational Conv2d. It adds output-channel count K, stride S, an optional ReLU, saturation, and a start/done handshake.
- Internally it uses one time-multiplexed MAC. Inputs are latched at start. Each output pixel is streamed as it completes, and the full result bus is also provided.
- It sits between the feature-map buffer and the next CRNN layer.

Parameters:
- N, 16: word width in bits (signed fixed point).
- Q, 8: number of fractional bits.
- h, 3: input height.
- w, 4: input width.
- c, 2: number of input channels.
- K, 2: number of output channels (filters).
- p, 1: zero padding on each side.
- S, 1: stride (S >= 1).
- RELU, 0: when 1, negative outputs are clamped to 0.
- Derived: OH = (h+2p-3)/S+1 and OW = (w+2p-3)/S+1, using integer division.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- global_rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin; accepted only in IDLE.
- data  in  N*h*w*c  input activations. Element (ci,r,x) is at bit ((ci*h+r)*w+x)*N.
- filterWeight  in  9*N*c*K  weights. Element (ko,ci,t), with t = ky*3+kx, is at bit ((ko*c+ci)*9+t)*N.
- filterBias  in  N*K  bias of filter ko, at bit ko*N.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the job completes.
- out_valid  out  1  one-cycle pulse per finished output pixel.
- out_data  out  N  pixel value; valid when out_valid is high.
- out_idx  out  clog2(K*OH*OW)  flat index (ko*OH+oy)*OW+ox of out_data.
- result  out  N*OH*OW*K  all outputs. Element (ko,oy,ox) is at bit ((ko*OH+oy)*OW+ox)*N.

Behaviour:
- Reset: while global_rst is low, all of the following are 0: busy, done, out_valid, out_data, out_idx, result, accumulator and all counters. The FSM is forced to IDLE. Reset may arrive mid-job; the job is abandoned and leaves no partial output.
- FSM states: IDLE, LOAD, MAC, WRITE, FIN.
- IDLE: start=1 moves to LOAD.
- LOAD (1 cycle):
  - Latches data, filterWeight and filterBias.
  - Sets busy=1 and clears the counters (ko, oy, ox, ci, t).
  - Later changes on the inputs have no effect on this job.
- MAC (exactly 9*c cycles per pixel):
  - One product per cycle, in order ci outer, t inner.
  - Source coordinate: iy = oy*S+ky-p, ix = ox*S+kx-p.
  - If iy or ix is outside the input, the operand is 0; the cycle is still spent.
- WRITE (1 cycle):
  - Computes the final value, writes it into result, and drives out_data/out_idx with out_valid=1.
  - Advances ox, then oy, then ko. Returns to MAC unless this was the last pixel, in which case it moves to FIN.
- FIN (1 cycle): done=1 and busy=0, then IDLE.
- Latency: start accepted at cycle 0 gives done at cycle 2 + K*OH*OW*(9c+1). For the defaults this is 458.
- Arithmetic:
  - Each product is 2N bits signed.
  - The accumulator is 2N+clog2(9c)+1 bits and cannot overflow.
  - The accumulator is initialised to sign-extended bias<<Q.
  - The final value is acc>>>Q (arithmetic shift, rounding toward -inf).
  - It is then saturated to [-2^(N-1), 2^(N-1)-1].
  - If RELU=1, negative results become 0 after saturation.
- start while busy, or in LOAD, MAC, WRITE or FIN, is ignored.
- start in the same cycle as the FIN-to-IDLE transition is ignored; it must be presented in IDLE.
- result holds its last value between jobs. It is overwritten pixel by pixel during the next job and is never cleared by start.
- out_valid and done never assert together. out_valid is 0 outside WRITE.

Test Plan:
- Bias only (defaults): filterWeight=0, bias raw 0x0001 for both filters, start -> all 24 result words are 0x0001; 24 out_valid pulses with out_idx 0..23 in order; done at cycle 458.
- Identity (defaults): ko=0 has ch0 centre tap 0x0100 and everything else 0. ch0 data is a ramp i*0x0100 for i=0..11 -> ko=0 outputs equal the ch0 input words. ko=1 (zero weights and bias) outputs 0.
- Saturation:
  - All data 0x7F00, all weights 0x7F00 -> every interior pixel is 0x7FFF.
  - Weights 0x8100 -> 0x8000.
  - Same with RELU=1 -> 0x0000.
- Stride/pad config: h=w=5, c=1, K=1, p=0, S=2, data and weights all 0x0100, bias 0 -> OH=OW=2, four outputs of 0x0900, done at cycle 2+4*10=42.
- Padding corner (defaults): all weights 0x0100, all data 0x0100, bias 0 -> corner output 0x0800 (4 taps x 2 ch), edge output 0x0C00, interior output 0x1200.
- Control:
  - start pulsed again mid-job -> ignored, and done timing is unchanged.
  - global_rst low during MAC -> busy, done, out_valid and result all go to 0 immediately.
  - Re-start after reset -> completes with correct values in 458 cycles.

Source files
------------

// File: rtl/conv2d_seq.sv
// conv2d_seq: K-filter 3x3 convolution over c channels, one signed MAC per cycle, pixels streamed as they finish.
// Latency 2 + K*OH*OW*(9c+1) cycles from start to done; start only accepted in IDLE, outputs have no backpressure.
module conv2d_seq #(
   parameter int N    = 16,
   parameter int Q    = 8,
   parameter int h    = 3,
   parameter int w    = 4,
   parameter int c    = 2,
   parameter int K    = 2,
   parameter int p    = 1,
   parameter int S    = 1,
   parameter int RELU = 0,
   localparam int OH   = (h + 2*p - 3) / S + 1,
   localparam int OW   = (w + 2*p - 3) / S + 1,
   localparam int NPIX = K * OH * OW,
   localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1
) (
   input  logic                  clk,
   input  logic                  global_rst,
   input  logic                  start,
   input  logic [N*h*w*c-1:0]    data,
   input  logic [9*N*c*K-1:0]    filterWeight,
   input  logic [N*K-1:0]        filterBias,
   output logic                  busy,
   output logic                  done,
   output logic                  out_valid,
   output logic [N-1:0]          out_data,
   output logic [IW-1:0]         out_idx,
   output logic [N*NPIX-1:0]     result
);

   localparam int AW  = 2*N + $clog2(9*c) + 1;
   localparam int KW  = (K > 1)  ? $clog2(K)  : 1;
   localparam int YW  = (OH > 1) ? $clog2(OH) : 1;
   localparam int XW  = (OW > 1) ? $clog2(OW) : 1;
   localparam int CW  = (c > 1)  ? $clog2(c)  : 1;
   localparam int DAW = $clog2(N*h*w*c);
   localparam int WAW = $clog2(9*N*c*K);
   localparam int BAW = (K > 1) ? $clog2(N*K) : $clog2(N);
   localparam int RAW = $clog2(N*NPIX);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] MAC   = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] FIN   = 3'd4;

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

   logic [2:0]            state;
   logic [N*h*w*c-1:0]    data_q;
   logic [9*N*c*K-1:0]    weight_q;
   logic [N*K-1:0]        bias_q;
   logic [KW-1:0]         ko;
   logic [YW-1:0]         oy;
   logic [XW-1:0]         ox;
   logic [CW-1:0]         ci;
   logic [1:0]            ky;
   logic [1:0]            kx;
   logic signed [AW-1:0]  acc;

   int                    iy;
   int                    ix;
   logic [DAW-1:0]        d_off;
   logic [WAW-1:0]        w_off;
   logic [BAW-1:0]        b_off;
   logic [RAW-1:0]        r_off;
   logic signed [N-1:0]   act;
   logic signed [N-1:0]   wgt;
   logic signed [N-1:0]   bias_sel;
   logic signed [2*N-1:0] prod;
   logic signed [AW-1:0]  acc_base;
   logic signed [AW-1:0]  shifted;
   logic [N-1:0]          pix_val;
   logic [IW-1:0]         pix_idx;
   logic                  last_tap;
   logic                  last_pix;

   // Padding taps still cost a cycle; the operand is simply forced to zero.
   always_comb begin
      iy    = int'(oy) * S + int'(ky) - p;
      ix    = int'(ox) * S + int'(kx) - p;
      d_off = '0;
      act   = '0;
      if (iy >= 0 && iy < h && ix >= 0 && ix < w) begin
         d_off = DAW'(((int'(ci) * h + iy) * w + ix) * N);
         act   = data_q[d_off +: N];
      end
      w_off    = WAW'(((int'(ko) * c + int'(ci)) * 9 + int'(ky) * 3 + int'(kx)) * N);
      wgt      = weight_q[w_off +: N];
      b_off    = BAW'(int'(ko) * N);
      bias_sel = bias_q[b_off +: N];
      prod     = (2*N)'(act) * (2*N)'(wgt);
      acc_base = (ci == '0 && ky == 2'd0 && kx == 2'd0) ? (AW'(bias_sel) <<< Q) : acc;

      shifted = acc >>> Q;
      if (shifted > SAT_MAX)
         pix_val = SAT_MAX[N-1:0];
      else if (shifted < SAT_MIN)
         pix_val = SAT_MIN[N-1:0];
      else
         pix_val = shifted[N-1:0];
      if (RELU != 0 && pix_val[N-1])
         pix_val = '0;

      pix_idx  = IW'((int'(ko) * OH + int'(oy)) * OW + int'(ox));
      r_off    = RAW'(int'(pix_idx) * N);
      last_tap = (int'(ci) == c - 1) && (ky == 2'd2) && (kx == 2'd2);
      last_pix = (int'(ko) == K - 1) && (int'(oy) == OH - 1) && (int'(ox) == OW - 1);
   end

   assign busy      = (state == LOAD) || (state == MAC) || (state == WRITE);
   assign done      = (state == FIN);
   assign out_valid = (state == WRITE);
   assign out_data  = out_valid ? pix_val : '0;
   assign out_idx   = out_valid ? pix_idx : '0;

   always_ff @(posedge clk or negedge global_rst) begin
      if (!global_rst) begin
         state    <= IDLE;
         data_q   <= '0;
         weight_q <= '0;
         bias_q   <= '0;
         ko       <= '0;
         oy       <= '0;
         ox       <= '0;
         ci       <= '0;
         ky       <= '0;
         kx       <= '0;
         acc      <= '0;
         result   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start)
                  state <= LOAD;
            end
            LOAD: begin
               data_q   <= data;
               weight_q <= filterWeight;
               bias_q   <= filterBias;
               ko       <= '0;
               oy       <= '0;
               ox       <= '0;
               ci       <= '0;
               ky       <= '0;
               kx       <= '0;
               acc      <= '0;
               state    <= MAC;
            end
            MAC: begin
               acc <= acc_base + AW'(prod);
               if (kx == 2'd2) begin
                  kx <= '0;
                  if (ky == 2'd2) begin
                     ky <= '0;
                     if (last_tap) begin
                        ci    <= '0;
                        state <= WRITE;
                     end else begin
                        ci <= ci + CW'(1);
                     end
                  end else begin
                     ky <= ky + 2'd1;
                  end
               end else begin
                  kx <= kx + 2'd1;
               end
            end
            WRITE: begin
               result[r_off +: N] <= pix_val;
               if (int'(ox) == OW - 1) begin
                  ox <= '0;
                  if (int'(oy) == OH - 1) begin
                     oy <= '0;
                     ko <= (int'(ko) == K - 1) ? '0 : ko + KW'(1);
                  end else begin
                     oy <= oy + YW'(1);
                  end
               end else begin
                  ox <= ox + XW'(1);
               end
               state <= last_pix ? FIN : MAC;
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
